// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms on a generator frame boundary, counts completed packets,
// stops cleanly at a packet boundary and guards the run with a packet-completion watchdog.
module acq_sequencer #(
    parameter int unsigned WDOG_CYCLES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_clear_ts,
    input  logic [15:0] num_packets,
    input  logic        pause_ts,
    input  logic [31:0] gen_status,
    output logic [31:0] gen_control,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] packets_done,
    output logic [2:0]  seq_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam int WDOG_W = 20;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        n_lat_q, n_lat_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               stop_pend_q, stop_pend_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               last_p1;
    logic               pause_p1;
    logic               en_q, en_d;
    logic               clr_q, clr_d;
    logic               clr_hold_q, clr_hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               fb;
    logic               pc;
    logic [15:0]        cnt_inc;
    logic               last_hit;
    logic               wdog_expire;
    logic               unused_status;

    assign unused_status = ^{gen_status[31:15], gen_status[0]};

    // Frame boundary is the last cycle of state 79; completion is the rise of last_packet_sent.
    assign fb          = (gen_status[8:2] == 7'd79) && (gen_status[14:9] == 6'd34);
    assign pc          = gen_status[1] && !last_p1;
    assign cnt_inc     = pc ? sat_inc16(cnt_q) : cnt_q;
    assign last_hit    = (n_lat_q != 16'd0) && (cnt_inc == n_lat_q - 16'd1);
    assign wdog_expire = !pc && (wdog_q >= WDOG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_lat_q     <= '0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            wdog_q      <= '0;
            last_p1     <= 1'b0;
            pause_p1    <= 1'b0;
            en_q        <= 1'b0;
            clr_q       <= 1'b0;
            clr_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_lat_q     <= n_lat_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            wdog_q      <= wdog_d;
            last_p1     <= gen_status[1];
            pause_p1    <= pause_ts;
            en_q        <= en_d;
            clr_q       <= clr_d;
            clr_hold_q  <= clr_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_start && !cmd_stop) state_d = S_ARM;
            S_ARM: begin
                if (cmd_stop)  state_d = S_IDLE;
                else if (fb)   state_d = S_RUN;
            end
            S_RUN: begin
                if (wdog_expire)                                       state_d = S_ERROR;
                else if (fb && (last_hit || stop_pend_q || cmd_stop)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pc)               state_d = S_IDLE;
                else if (wdog_expire) state_d = S_ERROR;
            end
            S_ERROR: if (cmd_stop) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values for every registered output and the counters behind them.
    always_comb begin
        n_lat_d     = n_lat_q;
        cnt_d       = cnt_q;
        stop_pend_d = 1'b0;
        wdog_d      = '0;
        done_d      = 1'b0;
        clr_hold_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_ARM) begin
                    n_lat_d = num_packets;
                    cnt_d   = '0;
                end
                clr_hold_d = cmd_clear_ts && !cmd_start;
            end
            S_RUN: begin
                cnt_d       = cnt_inc;
                stop_pend_d = (state_d == S_RUN) && (stop_pend_q || cmd_stop);
                wdog_d      = pc ? '0 : wdog_q + WDOG_W'(1);
            end
            S_DRAIN: begin
                cnt_d  = cnt_inc;
                wdog_d = pc ? '0 : wdog_q + WDOG_W'(1);
                done_d = pc;
            end
            default: ;
        endcase
        // Clear is held for the pulse cycle plus one more.
        clr_d  = clr_hold_d || clr_hold_q;
        en_d   = (state_d == S_RUN);
        busy_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
        err_d  = (state_d == S_ERROR);
    end

    assign gen_control  = {29'd0, pause_p1, clr_q, en_q};
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;
    assign packets_done = cnt_q;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with a frame-accurate generator model and a done scoreboard.
module tb_acq_sequencer;

    localparam int WDOG  = 3000;
    localparam int FRAME = 2800;

    logic        clk = 1'b0;
    logic        rst, cmd_start, cmd_stop, cmd_clear_ts, pause_ts;
    logic [15:0] num_packets;
    logic [31:0] gen_status, gen_control;
    logic        busy, done, error;
    logic [15:0] packets_done;
    logic [2:0]  seq_state;

    always #5 clk = ~clk;

    acq_sequencer #(.WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_clear_ts(cmd_clear_ts), .num_packets(num_packets), .pause_ts(pause_ts),
        .gen_status(gen_status), .gen_control(gen_control), .busy(busy), .done(done),
        .error(error), .packets_done(packets_done), .seq_state(seq_state)
    );

    // Generator model: free-running 80x35 frame; a packet starts when enable is seen at
    // position 0 and ends with tlast on the last cycle; last_packet_sent rises one cycle later.
    int   pos = 0;
    logic active = 1'b0, last_sent = 1'b0, gen_stall = 1'b0, gen_rst = 1'b1;
    int   tlast_cnt = 0, magic_cnt = 0, done_cnt = 0, en_hi_cnt = 0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (gen_control[0]) en_hi_cnt <= en_hi_cnt + 1;
        if (gen_rst) begin
            pos <= 0; active <= 1'b0; last_sent <= 1'b0;
        end else if (!gen_stall) begin
            pos <= (pos == FRAME - 1) ? 0 : pos + 1;
            last_sent <= 1'b0;
            if (pos == 0 && gen_control[0]) begin
                active <= 1'b1; magic_cnt <= magic_cnt + 1;
            end
            if (pos == FRAME - 1 && active) begin
                active <= 1'b0; last_sent <= 1'b1; tlast_cnt <= tlast_cnt + 1;
            end
        end
    end

    assign gen_status = {16'(tlast_cnt), 1'b0, 6'(pos % 35), 7'(pos / 35), last_sent, 1'b0};

    int total = 0, passed = 0, failed = 0;
    int exp_done_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (pos != p && n < FRAME + 10) begin step(); n++; end
        check("wait_pos", 32'(pos), 32'(p));
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (seq_state != s && n < budget) begin step(); n++; end
        check(tag, 32'(seq_state), 32'(s));
    endtask

    task automatic wait_pkts(input int k, input int budget, input string tag);
        int n = 0;
        while (packets_done != 16'(k) && n < budget) begin step(); n++; end
        check(tag, 32'(packets_done), 32'(k));
    endtask

    // Waits for the done pulse and scores it against the oldest expectation.
    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin step(); n++; end
        check({tag, "_seen"}, 32'(done), 32'd1);
        if (done) begin
            if (exp_done_q.size() == 0) check({tag, "_unexpected"}, 32'd1, 32'd0);
            else check({tag, "_count"}, 32'(packets_done), 32'(exp_done_q.pop_front()));
        end
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    endtask

    initial begin
        int tl0, mg0, d0, e0, k;
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear_ts = 1'b0;
        pause_ts = 1'b0; num_packets = 16'd0;
        repeat (3) step();
        rst = 1'b0; gen_rst = 1'b0;
        step();
        check("rst_state", 32'(seq_state), 32'd0);
        check("rst_ctrl", gen_control, 32'd0);
        check("rst_flags", {29'd0, busy, done, error}, 32'd0);
        check("rst_pkts", 32'(packets_done), 32'd0);

        pause_ts = 1'b1;
        check("pause_before_edge", 32'(gen_control[2]), 32'd0);
        step();
        check("pause_set", 32'(gen_control[2]), 32'd1);
        pause_ts = 1'b0; step();
        check("pause_clr", 32'(gen_control[2]), 32'd0);

        cmd_clear_ts = 1'b1; step(); cmd_clear_ts = 1'b0;
        check("clr_idle_c1", 32'(gen_control[1]), 32'd1);
        step();
        check("clr_idle_c2", 32'(gen_control[1]), 32'd1);
        step();
        check("clr_idle_c3", 32'(gen_control[1]), 32'd0);

        cmd_start = 1'b1; cmd_stop = 1'b1; step(); cmd_start = 1'b0; cmd_stop = 1'b0;
        check("start_stop_same", 32'(seq_state), 32'd0);
        check("start_stop_busy", 32'(busy), 32'd0);

        // Abort from ARM: enable and done must stay quiet.
        wait_pos(100);
        d0 = done_cnt; e0 = en_hi_cnt;
        pulse_start();
        check("arm_entry", 32'(seq_state), 32'd1);
        check("arm_busy", 32'(busy), 32'd1);
        pulse_start();
        check("arm_restart_ignored", 32'(seq_state), 32'd1);
        pulse_stop();
        check("arm_abort", 32'(seq_state), 32'd0);
        repeat (5) step();
        check("arm_abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("arm_abort_no_en", 32'(en_hi_cnt - e0), 32'd0);

        // Three-packet acquisition.
        num_packets = 16'd3;
        wait_pos(100);
        tl0 = tlast_cnt; mg0 = magic_cnt;
        pulse_start();
        exp_done_q.push_back(3);
        num_packets = 16'd7;
        check("n3_arm_en", 32'(gen_control[0]), 32'd0);
        wait_state(3'd2, FRAME + 10, "n3_run");
        check("n3_en_after_fb", 32'(gen_control[0]), 32'd1);
        check("n3_en_at_pos0", 32'(pos), 32'd0);
        cmd_clear_ts = 1'b1; step(); cmd_clear_ts = 1'b0;
        check("clr_run_c1", 32'(gen_control[1]), 32'd0);
        step();
        check("clr_run_c2", 32'(gen_control[1]), 32'd0);
        wait_done(4 * FRAME, "n3_done");
        check("n3_tlast", 32'(tlast_cnt - tl0), 32'd3);
        check("n3_idle", 32'(seq_state), 32'd0);
        check("n3_en_low", 32'(gen_control[0]), 32'd0);
        step();
        check("n3_done_one_cycle", 32'(done), 32'd0);
        repeat (FRAME + 100) step();
        check("n3_no_magic_after", 32'(magic_cnt - mg0), 32'd3);

        // Continuous acquisition stopped during packet 5.
        num_packets = 16'd0;
        wait_pos(100);
        tl0 = tlast_cnt; mg0 = magic_cnt;
        pulse_start();
        exp_done_q.push_back(5);
        wait_pkts(4, 6 * FRAME, "cont_pkts4");
        repeat (500) step();
        pulse_stop();
        check("cont_still_run", 32'(seq_state), 32'd2);
        wait_done(2 * FRAME, "cont_done");
        check("cont_tlast", 32'(tlast_cnt - tl0), 32'd5);
        repeat (FRAME + 100) step();
        check("cont_magic", 32'(magic_cnt - mg0), 32'd5);

        // Reset in the middle of a run.
        wait_pos(100);
        pulse_start();
        wait_pkts(2, 4 * FRAME, "rst_run_pkts2");
        repeat (300) step();
        check("rst_run_pre", 32'(gen_control[0]), 32'd1);
        rst = 1'b1; gen_rst = 1'b1; step(); rst = 1'b0; gen_rst = 1'b0;
        check("rst_run_ctrl", gen_control, 32'd0);
        check("rst_run_flags", {29'd0, busy, done, error}, 32'd0);
        check("rst_run_pkts", 32'(packets_done), 32'd0);
        check("rst_run_state", 32'(seq_state), 32'd0);

        // Watchdog: generator stalls right after the magic word.
        wait_pos(100);
        pulse_start();
        wait_state(3'd2, FRAME + 10, "wd_run");
        step(); gen_stall = 1'b1;
        k = 1;
        while (seq_state != 3'd4 && k < WDOG + 500) begin step(); k++; end
        check("wd_cycles", 32'(k), 32'(WDOG));
        check("wd_error", 32'(error), 32'd1);
        check("wd_en_low", 32'(gen_control[0]), 32'd0);
        check("wd_busy_low", 32'(busy), 32'd0);
        pulse_start();
        check("wd_start_ignored", 32'(seq_state), 32'd4);
        pulse_stop();
        check("wd_ack_state", 32'(seq_state), 32'd0);
        check("wd_ack_error", 32'(error), 32'd0);
        gen_stall = 1'b0;
        check("scoreboard_empty", 32'(exp_done_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter WDOG_CYCLES, default 8192, max cycles between packet completions in RUN/DRAIN before error (range 2801..1048575).
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmd_start  in  1  one-cycle pulse; begin acquisition.
REQ-005 cmd_stop  in  1  one-cycle pulse; stop at next packet boundary, or acknowledge error.
REQ-006 cmd_clear_ts  in  1  one-cycle pulse; zero generator timestamp.
REQ-007 num_packets  in  16  packets per acquisition; 0 = continuous.
REQ-008 pause_ts  in  1  level; forwarded to generator pause bit.
REQ-009 gen_status  in  32  generator status: [1] last_packet_sent, [8:2] state 0-79, [14:9] cycle 0-34, [31:16] packets_sent.
REQ-010 gen_control  out  32  generator control: [0] enable, [1] reset timestamp, [2] pause, [31:3] zero.
REQ-011 busy  out  1  high in ARM, RUN, DRAIN.
REQ-012 done  out  1  one-cycle pulse at acquisition end.
REQ-013 error  out  1  high in ERROR.
REQ-014 packets_done  out  16  packets completed this acquisition.
REQ-015 seq_state  out  3  IDLE=0, ARM=1, RUN=2, DRAIN=3, ERROR=4.

Function
REQ-016 All outputs registered; gen_control[2] = registered pause_ts (1-cycle latency) in every state.
REQ-017 Frame boundary (FB) = gen_status[8:2]==79 and gen_status[14:9]==34, sampled in the current cycle.
REQ-018 Packet completion (PC) = rising edge of gen_status[1] (registered previous value 0, current 1).
REQ-019 IDLE: cmd_start -> ARM; latch num_packets; clear packets_done; gen_control[0]=0.
REQ-020 IDLE: cmd_clear_ts (without cmd_start) -> gen_control[1]=1 for exactly 2 cycles, then 0; ignored outside IDLE.
REQ-021 ARM: on FB -> RUN, gen_control[0]=1 from the next cycle, so the generator first emits at state 0 cycle 0 (magic word); cmd_stop -> IDLE, no done pulse, enable never raised.
REQ-022 RUN: each PC increments packets_done (saturate at 0xFFFF) and clears watchdog.
REQ-023 RUN: on FB with (latched N!=0 and packets_done==N-1) or stop_pending -> gen_control[0]=0 next cycle, -> DRAIN; the final packet's tlast still emits, and no magic word follows.
REQ-024 cmd_stop in RUN sets stop_pending; cleared on leaving RUN.
REQ-025 DRAIN: on PC -> increment packets_done, done=1 for one cycle, -> IDLE.
REQ-026 Watchdog: counts cycles in RUN/DRAIN since entry or last PC; on reaching WDOG_CYCLES -> ERROR, gen_control[0]=0 next cycle.
REQ-027 ERROR: error=1, enable=0; cmd_stop -> IDLE; cmd_start ignored.
REQ-028 Simultaneous cmd_start and cmd_stop: stop wins (IDLE stays IDLE). cmd_start outside IDLE ignored. cmd_start with cmd_clear_ts in IDLE: start wins, clear dropped.
REQ-029 PC and FB in the same cycle: count PC first; evaluate REQ-023 against the updated count.
REQ-030 num_packets changes after start have no effect until the next start.

Reset
REQ-031 rst in any state -> IDLE; gen_control=0, busy=0, done=0, error=0, packets_done=0, seq_state=0, stop_pending=0, watchdog=0, PC edge register=0.
REQ-032 rst mid-RUN drops enable on the next cycle; a partial generator packet is acceptable.

Verification
REQ-033 num_packets=3, start, tready=1 -> enable rises the cycle after FB; exactly 3 tlast pulses (2800 cycles apart); done pulse; packets_done=3; no magic word after the third tlast.
REQ-034 num_packets=0, start, cmd_stop during packet 5 -> tlast on packet 5, then enable low; done pulse; packets_done=5.
REQ-035 cmd_start in ARM with cmd_stop on the next cycle -> IDLE, enable never 1, done never pulses.
REQ-036 cmd_clear_ts in IDLE -> gen_control[1]=1 for 2 cycles; cmd_clear_ts in RUN -> gen_control[1] stays 0.
REQ-037 WDOG_CYCLES=3000, tready held 0 after magic word -> ERROR at 3000 cycles, enable 0, error=1; cmd_stop -> IDLE, error 0.
REQ-038 rst asserted mid-RUN with packets_done=2 -> next cycle all outputs at reset values.
